// File: rtl/text_pkg.sv
// Shared types and constants for the text serialiser: FSM states, byte geometry
// and the end-of-text marker.
package text_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned BIT_CNT_W     = $clog2(BITS_PER_BYTE);

    localparam logic [BYTE_W-1:0] TEXT_TERM = 8'h00;

    typedef enum logic [1:0] {
        FETCH,
        LOAD,
        SHIFT,
        DONE
    } tx_state_t;

endpackage

// File: rtl/text_if.sv
// Output bundle of the text serialiser: serial line plus the reassembled byte stream.
interface text_if;
    import text_pkg::*;

    logic [BYTE_W-1:0] data_out;
    logic              data_valid;
    logic              tx_bit;
    logic              tx_valid;
    logic              done;

    modport master (output data_out, data_valid, tx_bit, tx_valid, done);
    modport slave  (input  data_out, data_valid, tx_bit, tx_valid, done);

endinterface

// File: rtl/text_source.sv
// Text source: a single-port synchronous ROM (altsyncram-style port and memory
// names) wrapped behind a byte-address read port.
module text_rom #(
    parameter int unsigned numwords_a = 256,
    parameter int unsigned widthad_a  = 8,
    parameter int unsigned width_a    = 8,
    parameter string       init_file  = ""
) (
    input  logic                 clock0,
    input  logic [widthad_a-1:0] address_a,
    input  logic [width_a-1:0]   data_a,
    input  logic                 wren_a,
    output logic [width_a-1:0]   q_a
);
    // The init image is bound by the vendor memory flow; the model only carries the name.
    localparam string unused_init_file = init_file;

    logic [width_a-1:0]   mem_data [numwords_a];
    logic [widthad_a-1:0] r_addr;

    // Registered address gives the one-cycle read latency; contents never see reset.
    always_ff @(posedge clock0) begin
        if (wren_a) begin
            mem_data[address_a] <= data_a;
        end
        r_addr <= address_a;
    end

    assign q_a = mem_data[r_addr];

endmodule

module text_source
    import text_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter string       INIT_FILE = "contents.txt"
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [BYTE_W-1:0] o_q
);

    text_rom #(
        .numwords_a (ROM_DEPTH),
        .widthad_a  (ADDR_W),
        .width_a    (BYTE_W),
        .init_file  (INIT_FILE)
    ) S (
        .clock0    (clk),
        .address_a (i_addr),
        .data_a    ('0),
        .wren_a    (1'b0),
        .q_a       (o_q)
    );

endmodule

// File: rtl/text_top.sv
// Streams a zero-terminated text ROM MSB-first onto a serial line and
// reassembles it with a loopback receiver.
module text_top
    import text_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 256,
    parameter string       ROM_INIT  = "contents.txt"
) (
    input  logic       clk,
    input  logic [3:0] KEY,
    text_if.master     o_bus
);

    localparam int unsigned ADDR_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    logic w_rst_n;
    logic w_unused_key;
    assign w_rst_n      = KEY[0];
    assign w_unused_key = ^KEY[3:1];

    tx_state_t             r_state,  w_state_nxt;
    logic [ADDR_W-1:0]     r_addr,   w_addr_nxt;
    logic [BYTE_W-1:0]     r_shreg,  w_shreg_nxt;
    logic [BIT_CNT_W-1:0]  r_bcnt,   w_bcnt_nxt;
    logic                  r_tx_bit, w_tx_bit_nxt;
    logic                  r_tx_valid, w_tx_valid_nxt;
    logic                  r_done;
    logic [BYTE_W-1:0]     w_rom_q;

    logic [BYTE_W-1:0]     r_rx_shreg;
    logic [BIT_CNT_W-1:0]  r_rx_cnt;
    logic [BYTE_W-1:0]     r_data_out;
    logic                  r_data_valid;

    text_source #(
        .ROM_DEPTH (ROM_DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (ROM_INIT)
    ) source (
        .clk    (clk),
        .i_addr (r_addr),
        .o_q    (w_rom_q)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= FETCH;
            r_addr     <= '0;
            r_shreg    <= '0;
            r_bcnt     <= '0;
            r_tx_bit   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_done     <= (r_state == DONE);
        end
    end

    // Transmit sequencing; the line outputs are registered, so each bit appears one cycle after its SHIFT state.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_shreg_nxt    = r_shreg;
        w_bcnt_nxt     = r_bcnt;
        w_tx_bit_nxt   = 1'b0;
        w_tx_valid_nxt = 1'b0;
        case (r_state)
            FETCH: w_state_nxt = LOAD;
            LOAD: begin
                if (w_rom_q == TEXT_TERM) begin
                    w_state_nxt = DONE;
                end else begin
                    w_shreg_nxt = w_rom_q;
                    w_bcnt_nxt  = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_tx_bit_nxt   = r_shreg[BYTE_W-1];
                w_tx_valid_nxt = 1'b1;
                w_shreg_nxt    = {r_shreg[BYTE_W-2:0], 1'b0};
                w_bcnt_nxt     = r_bcnt + BIT_CNT_W'(1);
                if (r_bcnt == BIT_CNT_W'(BITS_PER_BYTE - 1)) begin
                    // Last ROM location ends the text instead of wrapping the address.
                    if (r_addr == ADDR_W'(ROM_DEPTH - 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = FETCH;
                    end
                end
            end
            DONE: w_state_nxt = DONE;
        endcase
    end

    // Loopback receiver: LSB-end shift-in, publishes each completed byte for one cycle.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_shreg   <= '0;
            r_rx_cnt     <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (r_tx_valid) begin
                r_rx_shreg <= {r_rx_shreg[BYTE_W-2:0], r_tx_bit};
                r_rx_cnt   <= r_rx_cnt + BIT_CNT_W'(1);
                if (r_rx_cnt == BIT_CNT_W'(BITS_PER_BYTE - 1)) begin
                    r_data_out   <= {r_rx_shreg[BYTE_W-2:0], r_tx_bit};
                    r_data_valid <= 1'b1;
                end
            end
        end
    end

    assign o_bus.data_out   = r_data_out;
    assign o_bus.data_valid = r_data_valid;
    assign o_bus.tx_bit     = r_tx_bit;
    assign o_bus.tx_valid   = r_tx_valid;
    assign o_bus.done       = r_done;

endmodule

// File: tb/tb_text_top.sv
// Randomised self-checking bench for text_top against a cycle-indexed model of
// the text stream derived from the ROM image.
module tb_text_top;
    import text_pkg::*;

    localparam int unsigned DEPTH = 256;

    logic       clk = 1'b0;
    logic [3:0] KEY = 4'b0000;

    text_if bus ();

    text_top #(
        .ROM_DEPTH (DEPTH),
        .ROM_INIT  ("contents.txt")
    ) dut (
        .clk   (clk),
        .KEY   (KEY),
        .o_bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] rom_img [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_data_out"},   32'(bus.data_out),   32'h00);
        check({tag, "_data_valid"}, 32'(bus.data_valid), 32'h0);
        check({tag, "_tx_bit"},     32'(bus.tx_bit),     32'h0);
        check({tag, "_tx_valid"},   32'(bus.tx_valid),   32'h0);
        check({tag, "_done"},       32'(bus.done),       32'h0);
    endtask

    // Hold reset, load the image, and confirm the reset state.
    task automatic reset_and_load();
        KEY = 4'b0000;
        for (int i = 0; i < DEPTH; i++) begin
            dut.source.S.mem_data[i] <= rom_img[i];
        end
        repeat (3) @(negedge clk);
        check_idle("reset");
    endtask

    task automatic fill_random_text();
        for (int i = 0; i < DEPTH; i++) begin
            rom_img[i] = 8'($urandom_range(1, 255));
        end
    endtask

    // Release reset and compare every cycle against the expected stream.
    task automatic run_and_check(input int ncyc, input bit jitter);
        logic [7:0] bytes[$];
        logic [7:0] b;
        logic [7:0] exp_do;
        logic       exp_dv, exp_tv, exp_tb, exp_done;
        bit         term;
        int         n, done_cyc, off, pulses, exp_pulses;
        term   = 1'b0;
        pulses = 0;
        exp_pulses = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rom_img[i] == 8'h00) begin
                term = 1'b1;
                break;
            end
            bytes.push_back(rom_img[i]);
        end
        n = bytes.size();
        done_cyc = term ? 10 * n + 3 : 10 * n + 1;
        @(negedge clk);
        KEY[0] = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            exp_do = 8'h00;
            exp_dv = 1'b0;
            exp_tv = 1'b0;
            exp_tb = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (c == 11 + 10 * k) exp_dv = 1'b1;
                if (c >= 11 + 10 * k) exp_do = bytes[k];
                off = c - 3 - 10 * k;
                if (off >= 0 && off <= 7) begin
                    b      = bytes[k];
                    exp_tv = 1'b1;
                    exp_tb = b[7 - off];
                end
            end
            exp_done = (c >= done_cyc);
            check($sformatf("data_out@%0d", c),   32'(bus.data_out),   32'(exp_do));
            check($sformatf("data_valid@%0d", c), 32'(bus.data_valid), 32'(exp_dv));
            check($sformatf("tx_valid@%0d", c),   32'(bus.tx_valid),   32'(exp_tv));
            check($sformatf("tx_bit@%0d", c),     32'(bus.tx_bit),     32'(exp_tb));
            check($sformatf("done@%0d", c),       32'(bus.done),       32'(exp_done));
            if (bus.data_valid === 1'b1) pulses++;
            if (jitter) KEY[3:1] = 3'($urandom);
        end
        for (int k = 0; k < n; k++) begin
            if (11 + 10 * k <= ncyc) exp_pulses++;
        end
        check("pulse_count", 32'(pulses), 32'(exp_pulses));
    endtask

    task automatic set_hi_text();
        fill_random_text();
        rom_img[0] = 8'h48;
        rom_img[1] = 8'h69;
        rom_img[2] = 8'h00;
    endtask

    initial begin
        int len;

        // "Hi" then terminator, quiet and with KEY[3:1] noise.
        set_hi_text();
        reset_and_load();
        run_and_check(40, 1'b0);
        reset_and_load();
        run_and_check(40, 1'b1);

        // Empty text.
        fill_random_text();
        rom_img[0] = 8'h00;
        reset_and_load();
        run_and_check(30, 1'b0);

        // Full ROM with no terminator: ends at the last address.
        for (int i = 0; i < DEPTH; i++) rom_img[i] = 8'h41;
        reset_and_load();
        run_and_check(2580, 1'b0);

        // Random texts of random length.
        for (int t = 0; t < 4; t++) begin
            len = $urandom_range(1, 30);
            fill_random_text();
            rom_img[len] = 8'h00;
            reset_and_load();
            run_and_check(10 * len + 15, 1'b1);
        end

        // Reset during SHIFT of byte 1, then restart from address 0.
        set_hi_text();
        reset_and_load();
        run_and_check(15, 1'b0);
        #2 KEY[0] = 1'b0;
        #1 check_idle("async_reset");
        repeat (2) @(negedge clk);
        check_idle("held_reset");
        run_and_check(40, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/text_top.md
TEXT_TOP -- requirements
Module: text_top

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; reset is KEY[0], named as the codebase does.
REQ-002 Parameter ROM_DEPTH, default 256: number of text bytes in the source ROM.
REQ-003 Parameter ROM_INIT, default "contents.txt": hex init file for the source ROM.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 KEY  input  4  KEY[0] is the async active-low reset; KEY[3:1] SHALL be ignored.
REQ-006 data_out  output  8  last byte reassembled by the receiver.
REQ-007 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-008 tx_bit  output  1  serial line, MSB first.
REQ-009 tx_valid  output  1  high in every cycle that tx_bit carries a data bit.
REQ-010 done  output  1  sticky; high once the end of text is reached.

Function
REQ-011 Source ROM: ROM_DEPTH x 8, synchronous read with a registered address (1-cycle latency), preloadable from ROM_INIT.
REQ-012 The transmit FSM SHALL use the states FETCH, LOAD, SHIFT and DONE.
REQ-013 Transition out of reset: the FSM enters FETCH with addr=0 and starts automatically; there is no start key.
REQ-014 FETCH (1 cycle): present addr to the ROM; next state is LOAD.
REQ-015 LOAD (1 cycle): if rom_q==8'h00, go to DONE; otherwise load rom_q into an 8-bit shift register, set the bit counter to 0 and go to SHIFT.
REQ-016 SHIFT (exactly 8 cycles): tx_bit=shreg[7] and tx_valid=1; shift left each cycle; after the 8th bit, increment addr and go to FETCH.
REQ-017 Byte period: 10 clocks per character.
REQ-018 End of text, first condition: a 0x00 byte ends the text and is not transmitted.
REQ-019 End of text, second condition: after the byte at addr ROM_DEPTH-1 is sent, the FSM goes to DONE; addr SHALL NOT wrap.
REQ-020 DONE: absorbing state; tx_valid=0, tx_bit=0, done=1 until reset.
REQ-021 Receiver: in a cycle with tx_valid=1, shift tx_bit into an 8-bit register at the LSB end.
REQ-022 On the 8th received bit, the receiver SHALL register the assembled byte into data_out and pulse data_valid high for exactly 1 cycle.
REQ-023 Latency: for byte k (k from 0), data_valid SHALL be high in cycle 11+10k, counting the first rising edge after reset release as cycle 1.
REQ-024 tx_valid SHALL be low in FETCH and LOAD; tx_bit SHALL be 0 whenever tx_valid=0.

Reset
REQ-025 On KEY[0]=0, asynchronously: state=FETCH, addr=0, shreg=0, bit counters=0, data_out=8'h00, data_valid=0, tx_bit=0, tx_valid=0, done=0.
REQ-026 Reset mid-byte SHALL abandon the partial byte; no data_valid pulse for it; after release, transmission restarts at addr 0 with REQ-023 timing.
REQ-027 ROM contents SHALL NOT be affected by reset.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef, the byte width (8), the bits-per-byte constant and the terminator value 8'h00.
REQ-029 One sub-module text_source, instance name "source", SHALL contain the ROM, instance name "S".
REQ-030 The "S" instance SHALL be an altsyncram-compatible ROM so the bench can preload its memory hierarchically.
REQ-031 The FSM and receiver SHALL stay in text_top.

Verification
REQ-032 ROM="48 69 00": data_out=8'h48 at cycle 11 and 8'h69 at cycle 21; done=1 from cycle 23; exactly 2 data_valid pulses.
REQ-033 ROM[0]=8'h48: tx_bit over cycles 3..10 SHALL be 0,1,0,0,1,0,0,0.
REQ-034 ROM[0]=8'h00: no data_valid pulses; tx_valid never high; done=1 from cycle 3.
REQ-035 All 256 bytes=8'h41: 256 pulses, each with data_out=8'h41; last pulse at cycle 2561; done thereafter; no wrap to addr 0.
REQ-036 Drop KEY[0] low during SHIFT of byte 1: outputs reset immediately; after release, byte 0 is delivered again at cycle 11.
REQ-037 KEY[3:1] toggled randomly during a run SHALL produce results identical to REQ-032.
